// File: rtl/add_result_checker.sv
// Compares adder results against a reference sum delayed LATENCY cycles; counts passes/fails and latches the first mismatch.
// Compare lands LATENCY cycles after a pair is accepted; no backpressure, accepts one pair per cycle.
module add_result_checker #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1,
  parameter int NUM_TXN = 256,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              op_valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] res_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic              err_valid_o,
  output logic [CNT_W-1:0]  err_idx_o,
  output logic [DATA_W-1:0] err_exp_o,
  output logic [DATA_W-1:0] err_got_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] exp;
    logic [CNT_W-1:0]  idx;
  } slot_t;

  state_t             state;
  state_t             state_nxt;
  slot_t              slots [LATENCY];
  logic [CNT_W-1:0]   issue_cnt;
  logic [DATA_W-1:0]  sum;
  logic               start_ok;
  logic               accept;
  logic               last_accept;
  logic               cmp_en;
  logic               cmp_match;
  logic               pending;

  // Carry is intentionally dropped: the reference is the modulo-2^DATA_W sum.
  assign sum         = a_i + b_i;
  assign start_ok    = start_i && (state == IDLE || state == DONE);
  assign accept      = (state == RUN) && op_valid_i;
  assign last_accept = accept && (issue_cnt == CNT_W'(NUM_TXN - 1));
  assign cmp_en      = (state == RUN || state == DRAIN) && slots[LATENCY-1].vld;
  assign cmp_match   = (res_i == slots[LATENCY-1].exp);

  // Slots still in flight after this cycle's shift; the tail is compared now.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      pending = pending | slots[i].vld;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (!pending) state_nxt = DONE;
      DONE:    if (start_i) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        slots[i] <= '0;
      end
    end else if (start_ok) begin
      // Flush so a stale tail from a previous run is never compared.
      for (int i = 0; i < LATENCY; i++) begin
        slots[i] <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        slots[i] <= slots[i-1];
      end
      slots[0].vld <= accept;
      slots[0].exp <= sum;
      slots[0].idx <= issue_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      issue_cnt   <= '0;
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      err_valid_o <= 1'b0;
      err_idx_o   <= '0;
      err_exp_o   <= '0;
      err_got_o   <= '0;
    end else if (start_ok) begin
      issue_cnt   <= '0;
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      err_valid_o <= 1'b0;
      err_idx_o   <= '0;
      err_exp_o   <= '0;
      err_got_o   <= '0;
    end else begin
      if (accept) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (cmp_en) begin
        if (cmp_match) begin
          if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + 1'b1;
        end else begin
          if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
          if (!err_valid_o) begin
            err_valid_o <= 1'b1;
            err_idx_o   <= slots[LATENCY-1].idx;
            err_exp_o   <= slots[LATENCY-1].exp;
            err_got_o   <= res_i;
          end
        end
      end
    end
  end

  assign busy_o = (state == RUN) || (state == DRAIN);
  assign done_o = (state == DONE);

endmodule

// File: doc/add_result_checker.md
# add_result_checker

Self-checking result stage that sits directly downstream of the 8-bit adder top level. It taps the operand pair driven into the adder and the adder's result. It delays a reference sum by the adder's pipeline latency and compares it cycle-accurately against the adder output. It accumulates pass/fail counts and latches the first mismatch, so the bench reads a verdict instead of scanning waveforms.

## Interface
- DATA_W, 8, operand/result width
- LATENCY, 1, cycles from operand presentation to valid adder result; legal 1..8
- NUM_TXN, 256, operand pairs accepted per run
- CNT_W, 16, width of pass/fail/index counters

- clk_i  in  1  single clock, all state on rising edge
- reset_i  in  1  asynchronous, active-low reset; clears all state
- start_i  in  1  begin a run; honoured only in IDLE or DONE
- op_valid_i  in  1  a_i/b_i carry a pair being applied to the adder this cycle
- a_i  in  DATA_W  operand A, as driven to the adder
- b_i  in  DATA_W  operand B, as driven to the adder
- res_i  in  DATA_W  adder result
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  high in DONE
- pass_cnt_o  out  CNT_W  matching compares this run
- fail_cnt_o  out  CNT_W  mismatching compares this run
- err_valid_o  out  1  at least one mismatch latched this run
- err_idx_o  out  CNT_W  transaction index (0-based) of first mismatch
- err_exp_o  out  DATA_W  expected value at first mismatch
- err_got_o  out  DATA_W  res_i value at first mismatch

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_i goes to RUN. It clears counters, error latch, issue counter and delay line.
- RUN: each cycle with op_valid_i high pushes {1, (a_i+b_i) mod 2^DATA_W, issue index} into a LATENCY-deep shift register. The carry is discarded. The issue counter increments. Cycles without op_valid_i push an invalid slot. When the NUM_TXN-th pair is accepted, go to DRAIN.
- DRAIN: op_valid_i is ignored; invalid slots are pushed. When no valid slot remains in the shift register after this cycle's compare, go to DONE.
- DONE: results hold. start_i clears everything and goes to RUN. start_i is ignored in RUN and DRAIN.
- Compare: when the tail slot is valid, compare res_i with the slot's expected value.
  - Equal: pass_cnt_o +1.
  - Unequal: fail_cnt_o +1. If err_valid_o is low, latch idx, expected and res_i, and set err_valid_o.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Compares happen in RUN and DRAIN only. A stale valid tail slot at start_i is flushed, not compared.

## Timing
- Reset values: busy_o=0, done_o=0, all counters 0, err_valid_o=0, err_idx_o/err_exp_o/err_got_o=0, state IDLE, delay line all invalid.
- reset_i low mid-run aborts immediately to IDLE with the reset values above. No partial results are retained.
- Pair accepted at edge t is compared against res_i sampled at edge t+LATENCY. Counters and error fields update at that same edge and are visible after it.
- busy_o rises the edge after start_i sampled high.
- With back-to-back pairs, last pair accepted at edge t gives: DRAIN from t, last compare at t+LATENCY, done_o high after edge t+LATENCY, busy_o low at the same edge.
- A simultaneous op_valid_i and start_i in IDLE: the pair is not accepted. Acceptance begins the cycle after entry to RUN.
- Throughput: one pair per cycle; gaps are allowed and preserve alignment.

## Test plan
- Correct adder (LATENCY=1), NUM_TXN=4, pairs (1,2),(255,1),(128,128),(10,20) back-to-back:
  - Required: pass_cnt_o=4, fail_cnt_o=0, err_valid_o=0.
  - done_o high 1 cycle after the last pair.
- Force res_i=0x00 on the 3rd compare only (expected 0x2A from 20+22):
  - Required: fail_cnt_o=1, err_idx_o=2, err_exp_o=0x2A, err_got_o=0x00.
  - A later forced mismatch leaves the err fields unchanged.
- Wrap-around with pair (200,100):
  - Required: expected 0x2C (44); an adder output of 44 counts as a pass.
- LATENCY=3, op_valid_i toggling 1,0,1,0,... over 8 pairs:
  - Required: all 8 pass.
  - done_o rises 3 cycles after the 8th pair is accepted.
- Assert reset_i low for 1 cycle mid-RUN after 5 of 10 pairs:
  - Required: all outputs at reset values; state IDLE; later start_i runs cleanly with counts from 0.
- start_i pulsed in RUN, then again in DONE:
  - Required: the first pulse has no effect; the second clears pass_cnt_o to 0 and busy_o rises the next cycle.
